min_countdown_ctrl: RTL and testbench
=====================================

// Module: min_countdown_ctrl
// PURPOSE
//  Downstream stage of the 59..0 seconds down-counter in the countdown timer.
//  Consumes its per-minute borrow pulse and its zero flag, and holds the minutes count.
//  Runs the IDLE/RUN/PAUSE/DONE control FSM and gates the seconds counter.
//  Raises done/alarm when mm:ss reaches 00:00.
// PARAMETERS
//  MIN_W       7   width of minutes count
//  MAX_MIN     99  saturation limit for loaded minutes
//  ALARM_SECS  10  number of tick_1hz pulses the alarm stays high in DONE
//  ALARM_W     4   width of alarm second counter, must hold ALARM_SECS
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  tick_1hz    in   1      1-cycle pulse per second from prescaler
//  sec_borrow  in   1      1-cycle pulse from seconds stage, cycle its value goes 0->59
//  sec_zero    in   1      seconds stage value == 0
//  start       in   1      1-cycle pulse: start / resume / acknowledge alarm
//  pause       in   1      1-cycle pulse: pause while running
//  clear       in   1      1-cycle pulse: abort, minutes <- 0
//  load        in   1      1-cycle pulse: load_min -> minutes (IDLE only)
//  load_min    in   MIN_W  minutes preset value
//  min_q       out  MIN_W  current minutes
//  sec_en      out  1      enable for seconds stage (combinational)
//  sec_clr     out  1      1-cycle clear to seconds stage on accepted load/clear
//  state_o     out  2      FSM state (timer_pkg encoding)
//  done        out  1      high while in DONE
//  alarm       out  1      high in DONE until ALARM_SECS ticks elapse
// BEHAVIOUR
//  Reset: state IDLE; min_q=0, done=0, alarm=0, alarm cnt=0.
//   sec_en=0 and sec_clr=0 follow combinationally.
//  Priority each cycle: clear > load > start > pause.
//  clear (any state): next state IDLE, min_q<=0, sec_clr=1 that cycle.
//  IDLE: load -> min_q <= min(load_min, MAX_MIN), sec_clr=1.
//   start with (min_q!=0 || !sec_zero) -> RUN.
//   start with zero time -> stay IDLE (no-op).
//  RUN: sec_en = !(min_q==0 && sec_zero).
//   sec_borrow -> min_q <= min_q-1; saturates at 0, never wraps.
//   min_q==0 && sec_zero -> DONE next cycle; sec_en already 0 in that cycle.
//   pause -> PAUSE. load and start are ignored.
//   Simultaneous pause and sec_borrow: decrement still applied.
//  PAUSE: sec_en=0; sec_borrow ignored; start -> RUN; load and pause ignored.
//  DONE: done=1; alarm=1 while alarm cnt < ALARM_SECS.
//   Each tick_1hz increments the alarm cnt.
//   When cnt reaches ALARM_SECS: alarm=0, stay DONE.
//   start -> IDLE; alarm cnt cleared on every DONE entry/exit.
//  All outputs registered except sec_en and sec_clr.
//  Latency of state change: 1 cycle after the input pulse.
//  Reset mid-RUN or mid-DONE: back to reset values next edge.
// STRUCTURE
//  timer_pkg: typedef enum logic [1:0] {IDLE=0,RUN=1,PAUSE=2,DONE=3} tstate_t.
//   Also holds MAX_MIN, shared with the seconds stage and display stages.
//  Sub-module timer_alarm_cnt: ALARM_W saturating counter.
//   Inputs: clr, en=tick_1hz. Output: expired.
// TESTING
//  load_min=5, load, start -> RUN; 4 sec_borrow pulses -> min_q=1; sec_en=1.
//  load_min=120 in IDLE -> min_q=99; load_min=3 in RUN -> min_q unchanged.
//  min_q=0, sec_zero=1 in RUN -> sec_en=0 same cycle; DONE next; done=1, alarm=1.
//  DONE, 10 tick_1hz -> alarm=0 after 10th; start -> IDLE, done=0.
//  RUN, pause+sec_borrow same cycle -> PAUSE, min_q decremented once; start -> RUN.
//  clear+load same cycle in IDLE -> min_q=0, sec_clr=1; reset in RUN -> IDLE, min_q=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer stages: FSM state encoding and
// the minutes saturation limit used by the seconds and display stages as well.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } tstate_t;

  // Largest minutes value a load may place in the counter.
  localparam int MAX_MIN = 99;

endpackage

// File: rtl/min_countdown_ctrl_if.sv
// Control/status bundle between the minutes controller and its neighbours:
// the seconds stage pulses, user command pulses and controller status.
interface min_countdown_ctrl_if #(
  parameter int MIN_W = 7
);
  import timer_pkg::*;

  logic             tick_1hz;
  logic             sec_borrow;
  logic             sec_zero;
  logic             start;
  logic             pause;
  logic             clear;
  logic             load;
  logic [MIN_W-1:0] load_min;
  logic [MIN_W-1:0] min_q;
  logic             sec_en;
  logic             sec_clr;
  tstate_t          state_o;
  logic             done;
  logic             alarm;

  // Driver side: seconds stage and user commands.
  modport master (
    output tick_1hz, sec_borrow, sec_zero, start, pause, clear, load, load_min,
    input  min_q, sec_en, sec_clr, state_o, done, alarm
  );

  // Controller side.
  modport slave (
    input  tick_1hz, sec_borrow, sec_zero, start, pause, clear, load, load_min,
    output min_q, sec_en, sec_clr, state_o, done, alarm
  );

endinterface

// File: rtl/timer_alarm_cnt.sv
// Saturating count of 1 Hz ticks spent in DONE; expired once the alarm
// duration has fully elapsed. Held at zero whenever clr is high.
module timer_alarm_cnt #(
  parameter int ALARM_SECS = 10,
  parameter int ALARM_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [ALARM_W-1:0] LIMIT = ALARM_W'(ALARM_SECS);

  logic [ALARM_W-1:0] cnt;

  // Count enabled ticks, stop at LIMIT so the count never wraps back to quiet.
  // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && (cnt != LIMIT))
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/min_countdown_ctrl.sv
// Minutes stage of the countdown timer: holds mm, runs the IDLE/RUN/PAUSE/DONE
// control FSM, gates the seconds stage and raises done/alarm at 00:00.
module min_countdown_ctrl #(
  parameter int MIN_W      = 7,
  parameter int MAX_MIN    = timer_pkg::MAX_MIN,
  parameter int ALARM_SECS = 10,
  parameter int ALARM_W    = 4
) (
  input logic                clk,
  input logic                reset,
  min_countdown_ctrl_if.slave bus
);
  import timer_pkg::*;

  localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

  tstate_t          state_r;
  logic [MIN_W-1:0] min_r;
  logic             done_r;
  logic             alarm_expired;
  logic             time_zero;

  // mm:ss is 00:00 exactly when minutes are zero and the seconds stage is at zero.
  assign time_zero = (min_r == '0) && bus.sec_zero;

  // Control FSM with minutes count and done flag; clear beats every other command.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state_r <= IDLE;
      min_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.load)
            min_r <= (bus.load_min > MAX_MIN_V) ? MAX_MIN_V : bus.load_min;
          else if (bus.start && !time_zero)
            state_r <= RUN;
        end
        RUN: begin
          // A borrow arriving with pause is still honoured so no second is lost.
          if (bus.sec_borrow && (min_r != '0))
            min_r <= min_r - 1'b1;
          if (time_zero) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else if (bus.pause) begin
            state_r <= PAUSE;
          end
        end
        PAUSE: begin
          if (bus.start)
            state_r <= RUN;
        end
        DONE: begin
          if (bus.start) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Alarm duration counter, held clear outside DONE so it restarts on every entry.
  timer_alarm_cnt #(
    .ALARM_SECS (ALARM_SECS),
    .ALARM_W    (ALARM_W)
  ) u_alarm_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_r != DONE),
    .en      (bus.tick_1hz && (state_r == DONE)),
    .expired (alarm_expired)
  );

  assign bus.min_q   = min_r;
  assign bus.state_o = state_r;
  assign bus.done    = done_r;
  // Both operands are flops, so alarm has no combinational path from inputs.
  assign bus.alarm   = done_r && !alarm_expired;
  // Seconds stage stops in the very cycle 00:00 is seen, before DONE is entered.
  assign bus.sec_en  = (state_r == RUN) && !time_zero;
  assign bus.sec_clr = bus.clear || ((state_r == IDLE) && bus.load);

endmodule

// File: tb/tb_min_countdown_ctrl.sv
// Self-checking bench for min_countdown_ctrl: directed scenarios followed by
// randomized commands with an emulated 59..0 seconds stage, against a
// behavioural model of the timer.
module tb_min_countdown_ctrl;

  localparam int MIN_W      = 7;
  localparam int MAX_MIN    = 99;
  localparam int ALARM_SECS = 10;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk;
  logic reset;

  min_countdown_ctrl_if #(.MIN_W(MIN_W)) bus ();

  min_countdown_ctrl #(
    .MIN_W      (MIN_W),
    .MAX_MIN    (MAX_MIN),
    .ALARM_SECS (ALARM_SECS),
    .ALARM_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode, minutes remaining, ticks heard since reaching 00:00.
  int m_state;
  int m_min;
  int m_ticks;
  // Emulated seconds stage value.
  int sec_val;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_sec_en(input bit zero);
    return (m_state == S_RUN) && !((m_min == 0) && zero);
  endfunction

  function automatic bit exp_sec_clr(input bit cl, input bit ld);
    return cl || ((m_state == S_IDLE) && ld);
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_min   = 0;
    m_ticks = 0;
  endtask

  task automatic model_update(input bit tk, bw, zr, st, ps, cl, ld, input int lm);
    int old_min;
    old_min = m_min;
    if (cl) begin
      model_reset();
    end else if (m_state == S_IDLE) begin
      if (ld)
        m_min = (lm > MAX_MIN) ? MAX_MIN : lm;
      else if (st && (old_min != 0 || !zr))
        m_state = S_RUN;
    end else if (m_state == S_RUN) begin
      if (bw && old_min > 0)
        m_min = old_min - 1;
      if (old_min == 0 && zr) begin
        m_state = S_DONE;
        m_ticks = 0;
      end else if (ps) begin
        m_state = S_PAUSE;
      end
    end else if (m_state == S_PAUSE) begin
      if (st)
        m_state = S_RUN;
    end else begin
      if (st) begin
        m_state = S_IDLE;
        m_ticks = 0;
      end else if (tk) begin
        m_ticks = m_ticks + 1;
      end
    end
  endtask

  task automatic check_regs();
    check("state_o", int'(bus.state_o), m_state);
    check("min_q",   int'(bus.min_q),   m_min);
    check("done",    int'(bus.done),    int'(m_state == S_DONE));
    check("alarm",   int'(bus.alarm),   int'((m_state == S_DONE) && (m_ticks < ALARM_SECS)));
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic cycle(input bit tk, bw, zr, st, ps, cl, ld, input int lm);
    bit e_en;
    bit e_clr;
    bus.tick_1hz   = tk;
    bus.sec_borrow = bw;
    bus.sec_zero   = zr;
    bus.start      = st;
    bus.pause      = ps;
    bus.clear      = cl;
    bus.load       = ld;
    bus.load_min   = lm[MIN_W-1:0];
    e_en  = exp_sec_en(zr);
    e_clr = exp_sec_clr(cl, ld);
    #4;
    check("sec_en",  int'(bus.sec_en),  int'(e_en));
    check("sec_clr", int'(bus.sec_clr), int'(e_clr));
    model_update(tk, bw, zr, st, ps, cl, ld, lm);
    @(posedge clk);
    #1;
    if (e_clr)
      sec_val = 0;
    else if (e_en && tk)
      sec_val = (sec_val == 0) ? 59 : sec_val - 1;
    check_regs();
  endtask

  task automatic idle_inputs();
    bus.tick_1hz   = 1'b0;
    bus.sec_borrow = 1'b0;
    bus.sec_zero   = 1'b1;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.load_min   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    sec_val = 0;
    check_regs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    sec_val = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_state", int'(bus.state_o), S_IDLE);
    check("rst_min",   int'(bus.min_q),   0);
    check("rst_done",  int'(bus.done),    0);
    check("rst_alarm", int'(bus.alarm),   0);
    check("rst_sec_en", int'(bus.sec_en), 0);
    check("rst_sec_clr", int'(bus.sec_clr), 0);
    #3;

    // Load 5, start, four borrows -> 1 minute left and still counting.
    cycle(0, 0, 1, 0, 0, 0, 1, 5);
    cycle(0, 0, 1, 1, 0, 0, 0, 0);
    check("run_after_start", int'(bus.state_o), S_RUN);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
    end
    check("min_after_4_borrows", int'(bus.min_q), 1);
    check("sec_en_running", int'(bus.sec_en), 1);

    // Load and start are ignored while running.
    cycle(0, 0, 0, 0, 0, 0, 1, 3);
    check("load_in_run", int'(bus.min_q), 1);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);

    // Pause and borrow together: decrement applied, then resume.
    cycle(1, 1, 0, 0, 1, 0, 0, 0);
    check("pause_state", int'(bus.state_o), S_PAUSE);
    check("pause_min", int'(bus.min_q), 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check("borrow_in_pause", int'(bus.min_q), 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    check("resume_state", int'(bus.state_o), S_RUN);

    // Seconds reach zero with zero minutes: sec_en drops now, DONE next cycle.
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    check("done_state", int'(bus.state_o), S_DONE);
    check("done_flag", int'(bus.done), 1);
    check("alarm_on", int'(bus.alarm), 1);

    // Alarm lasts exactly ALARM_SECS ticks.
    for (int i = 1; i <= ALARM_SECS; i++) begin
      cycle(1, 0, 1, 0, 0, 0, 0, 0);
      if (i == ALARM_SECS - 1) check("alarm_before_last", int'(bus.alarm), 1);
      cycle(0, 0, 1, 0, 0, 0, 0, 0);
    end
    check("alarm_off", int'(bus.alarm), 0);
    check("still_done", int'(bus.state_o), S_DONE);
    cycle(1, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0, 0);
    check("ack_idle", int'(bus.state_o), S_IDLE);
    check("ack_done", int'(bus.done), 0);

    // Saturating load, clear beating load, zero-time start, start on seconds only.
    cycle(0, 0, 1, 0, 0, 0, 1, 120);
    check("load_sat", int'(bus.min_q), MAX_MIN);
    cycle(0, 0, 1, 0, 0, 1, 1, 7);
    check("clear_over_load", int'(bus.min_q), 0);
    cycle(0, 0, 1, 1, 0, 0, 0, 0);
    check("zero_start_noop", int'(bus.state_o), S_IDLE);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    check("start_on_secs", int'(bus.state_o), S_RUN);

    // Reset in the middle of a run.
    cycle(0, 0, 1, 0, 0, 0, 1, 2);
    do_reset();
    cycle(0, 0, 1, 0, 0, 0, 1, 2);
    cycle(0, 0, 1, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0, 0);
    do_reset();
    check("reset_mid_run", int'(bus.state_o), S_IDLE);

    // Randomized commands against an emulated seconds stage.
    sec_val = 0;
    for (int c = 0; c < 6000; c++) begin
      bit tk, zr, bw, st, ps, cl, ld;
      int lm;
      tk = ($urandom_range(0, 1) == 0);
      zr = (sec_val == 0);
      bw = tk && exp_sec_en(zr) && (sec_val == 0);
      st = ($urandom_range(0, 39) == 0);
      ps = ($urandom_range(0, 59) == 0);
      cl = ($urandom_range(0, 499) == 0);
      ld = ($urandom_range(0, 29) == 0);
      lm = ($urandom_range(0, 9) == 0) ? $urandom_range(96, 127) : $urandom_range(0, 2);
      if (c % 1500 == 700) begin
        do_reset();
      end else begin
        cycle(tk, bw, zr, st, ps, cl, ld, lm);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
